// File: rtl/rv_test_pkg.sv
// ============================================================================
// Module : rv_test_pkg
// Shared constants, bus FSM state type and tohost result decode for the
// riscv-tests responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_test_pkg;

   localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
   localparam logic [31:0] TOHOST_PASS         = 32'h0000_0001;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   typedef struct packed {
      logic        done;
      logic        pass;
      logic [30:0] num;
   } result_t;

   // Odd tohost values end the test; 1 is pass, anything else carries the failing test number.
   function automatic result_t result_from_tohost(input logic [31:0] value);
      result_t r;
      r.done = value[0];
      r.pass = (value == TOHOST_PASS);
      r.num  = r.pass ? 31'd0 : value[31:1];
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tohost_watchdog.sv
// ============================================================================
// Module : tohost_watchdog
// Saturating cycle counter that flags expiry while no test result exists.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tohost_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic done,
   output logic expired
);

   localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (!done && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

   assign expired = !done && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/tohost_responder.sv
// ============================================================================
// Module : tohost_responder
// Data-bus responder holding the riscv-tests tohost word and decoding the
// pass/fail result. Optional watchdog: TOHOST_RESPONDER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tohost_responder
   import rv_test_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
   parameter int unsigned DATA_W      = 32
`ifdef TOHOST_RESPONDER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 5000
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                test_done,
   output logic                test_pass,
   output logic [30:0]         test_num,
   output logic                timeout
);

   state_t            state;
   logic [DATA_W-1:0] tohost;
   logic [DATA_W-1:0] merged;
   logic              accept;
   logic              hit;
   logic              take_result;
   logic              take_timeout;
   result_t           res;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^req_addr[1:0];

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign hit       = (req_addr[31:2] == TOHOST_ADDR[31:2]);

   always_comb begin
      merged = tohost;
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (req_wstrb[b]) begin
            merged[b*8 +: 8] = req_wdata[b*8 +: 8];
         end
      end
   end

   assign res         = result_from_tohost(merged[31:0]);
   assign take_result = accept && req_we && hit && (|req_wstrb) && res.done && !test_done;

`ifdef TOHOST_RESPONDER_TIMEOUT_EN
   logic expired;

   tohost_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .done    (test_done),
      .expired (expired)
   );

   // A result landing on the expiry cycle takes precedence over the timeout.
   assign take_timeout = expired && !take_result;
`else
   assign take_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tohost     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         test_done  <= 1'b0;
         test_pass  <= 1'b0;
         test_num   <= '0;
         timeout    <= 1'b0;
      end else begin
         resp_valid <= accept;
         resp_rdata <= (accept && !req_we && hit) ? tohost : '0;

         case (state)
            IDLE:    if (accept) state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (accept && req_we && hit) begin
            tohost <= merged;
         end

         if (take_result) begin
            test_done <= 1'b1;
            test_pass <= res.pass;
            test_num  <= res.num;
         end else if (take_timeout) begin
            test_done <= 1'b1;
            test_pass <= 1'b0;
            test_num  <= '0;
            timeout   <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tohost_responder.sv
// ============================================================================
// Module : tb_tohost_responder
// Directed self-checking bench for tohost_responder (TOHOST_RESPONDER_TIMEOUT_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tohost_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        test_done;
   logic        test_pass;
   logic [30:0] test_num;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rd;

   always #5 clk = ~clk;

`ifdef TOHOST_RESPONDER_TIMEOUT_EN
   tohost_responder #(
      .TOHOST_ADDR    (32'h0000_1000),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (20)
   ) dut (
`else
   tohost_responder #(
      .TOHOST_ADDR    (32'h0000_1000),
      .DATA_W         (32)
   ) dut (
`endif
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .test_done  (test_done),
      .test_pass  (test_pass),
      .test_num   (test_num),
      .timeout    (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // One request: accepted at the next edge, response observed in RESP, back in IDLE after.
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      tick();
      check("resp_valid_pulse", {31'd0, resp_valid}, 32'd1);
      check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      rdata     = resp_rdata;
      req_valid = 1'b0;
      tick();
      check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      // Reset state
      do_reset();
      rst = 1'b0;
      #1;
      check("rst_ready",      {31'd0, req_ready},  32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata,          32'd0);
      check("rst_done",       {31'd0, test_done},  32'd0);
      check("rst_pass",       {31'd0, test_pass},  32'd0);
      check("rst_num",        {1'b0, test_num},    32'd0);
      check("rst_timeout",    {31'd0, timeout},    32'd0);

      // Watchdog behaviour with no stores
      do_reset();
`ifdef TOHOST_RESPONDER_TIMEOUT_EN
      repeat (19) tick();
      check("wd_edge19_timeout", {31'd0, timeout},   32'd0);
      check("wd_edge19_done",    {31'd0, test_done}, 32'd0);
      tick();
      check("wd_edge20_timeout", {31'd0, timeout},   32'd1);
      check("wd_edge20_done",    {31'd0, test_done}, 32'd1);
      check("wd_edge20_pass",    {31'd0, test_pass}, 32'd0);
      check("wd_edge20_num",     {1'b0, test_num},   32'd0);

      // Pass result accepted on the expiry cycle wins over the timeout
      do_reset();
      repeat (19) tick();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_1000;
      req_wdata = 32'h0000_0001;
      req_wstrb = 4'hF;
      tick();
      req_valid = 1'b0;
      check("tie_done",    {31'd0, test_done}, 32'd1);
      check("tie_pass",    {31'd0, test_pass}, 32'd1);
      check("tie_timeout", {31'd0, timeout},   32'd0);
      tick();
`else
      repeat (40) tick();
      check("nowd_timeout", {31'd0, timeout},   32'd0);
      check("nowd_done",    {31'd0, test_done}, 32'd0);
`endif

      // Pass
      do_reset();
      xfer(1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, rd);
      check("pass_store_rdata", rd, 32'd0);
      check("pass_done", {31'd0, test_done}, 32'd1);
      check("pass_pass", {31'd0, test_pass}, 32'd1);
      check("pass_num",  {1'b0, test_num},   32'd0);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("pass_load", rd, 32'h0000_0001);
      check("pass_timeout", {31'd0, timeout}, 32'd0);

      // Fail, then first result stays frozen
      do_reset();
      xfer(1'b1, 32'h0000_1000, 32'h0000_0007, 4'hF, rd);
      check("fail_done", {31'd0, test_done}, 32'd1);
      check("fail_pass", {31'd0, test_pass}, 32'd0);
      check("fail_num",  {1'b0, test_num},   32'd3);
      xfer(1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, rd);
      check("fail_frozen_pass", {31'd0, test_pass}, 32'd0);
      check("fail_frozen_num",  {1'b0, test_num},   32'd3);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("fail_load_after", rd, 32'h0000_0001);

      // Byte merge, ignored address LSBs, zero strobe, back-to-back handshake
      do_reset();
      xfer(1'b1, 32'h0000_1000, 32'hAB00_0000, 4'h8, rd);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("merge_msb_load", rd, 32'hAB00_0000);
      check("merge_done", {31'd0, test_done}, 32'd0);
      xfer(1'b1, 32'h0000_1003, 32'h0000_00CC, 4'h1, rd);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("merge_lsb_load", rd, 32'hAB00_00CC);
      xfer(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'h0, rd);
      xfer(1'b0, 32'h0000_1002, 32'h0, 4'h0, rd);
      check("zero_strb_load", rd, 32'hAB00_00CC);
      check("zero_strb_done", {31'd0, test_done}, 32'd0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_1000;
      tick();
      check("b2b_resp1",   {31'd0, resp_valid}, 32'd1);
      check("b2b_ready_0", {31'd0, req_ready},  32'd0);
      tick();
      check("b2b_gap_resp",  {31'd0, resp_valid}, 32'd0);
      check("b2b_ready_1",   {31'd0, req_ready},  32'd1);
      tick();
      check("b2b_resp2",   {31'd0, resp_valid}, 32'd1);
      check("b2b_rdata2",  resp_rdata,          32'hAB00_00CC);
      req_valid = 1'b0;
      tick();
      check("b2b_done", {31'd0, test_done}, 32'd0);
      check("b2b_timeout", {31'd0, timeout}, 32'd0);

      // Miss, then reset while in RESP
      do_reset();
      xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, rd);
      check("miss_load", rd, 32'd0);
      xfer(1'b1, 32'h0000_1000, 32'h0000_0002, 4'hF, rd);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("even_store_load", rd, 32'h0000_0002);
      check("even_store_done", {31'd0, test_done}, 32'd0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_1000;
      tick();
      check("mid_resp_before", {31'd0, resp_valid}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_resp_abort",  {31'd0, resp_valid}, 32'd0);
      check("mid_ready",       {31'd0, req_ready},  32'd1);
      check("mid_rdata",       resp_rdata,          32'd0);
      req_valid = 1'b0;
      tick();
      check("mid_no_pulse", {31'd0, resp_valid}, 32'd0);
      rst = 1'b1;
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd);
      check("mid_tohost_cleared", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
